lemon_ifu: RTL and testbench

- Multi-cycle instruction fetch unit; next generation of the single-cycle PC/fetch path.
- Owns the architectural PC and issues fetch requests over a valid/ready memory request channel, replacing the combinational memory read.
- Delivers 32-bit instructions with their PC to decode over a valid/ready channel.
- Accepts branch/jump redirects at any time; parametrised in XLEN, memory data width and reset vector.

---
 rtl/lemon_pkg.sv | 22 ++
 rtl/ifu_word_sel.sv | 27 ++
 rtl/lemon_ifu.sv | 162 ++++++++++++++++
 tb/tb_lemon_ifu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemon_pkg.sv
// rtl/lemon_pkg.sv - shared types and constants for the lemon fetch path
//
// Purpose: fetch-state encoding, instruction length and the core-wide default
// reset vector, imported by the instruction fetch unit and its helpers.
// Ports: none (package).

package lemon_pkg;

  localparam int ILEN = 32;

  // Default boot address, shared with the rest of the core.
  localparam logic [63:0] DEFAULT_RESET_VEC = 64'h0000_0000_8000_0000;

  // IFU_FAULT is reachable only when IFU_MISALIGN_CHK_EN is defined.
  typedef enum logic [1:0] {
    IFU_REQ,
    IFU_WAIT,
    IFU_OUT,
    IFU_FAULT
  } ifu_state_e;

endpackage

// File: rtl/ifu_word_sel.sv
// rtl/ifu_word_sel.sv - picks the 32-bit instruction out of a memory beat
//
// Purpose: combinational selection of the instruction word from the response
// data. A 64-bit beat carries two words, chosen by pc[2]; a 32-bit beat is
// passed through.
// Ports:
//   rsp_data  in  MEM_DW  memory response data
//   pc_bit2   in  1       bit 2 of the fetch PC
//   inst_word out ILEN    selected instruction

module ifu_word_sel
  import lemon_pkg::*;
#(
  parameter int MEM_DW = 64
) (
  input  logic [MEM_DW-1:0] rsp_data,
  input  logic              pc_bit2,
  output logic [ILEN-1:0]   inst_word
);

  if (MEM_DW == 64) begin : g_dw64
    assign inst_word = pc_bit2 ? rsp_data[63:32] : rsp_data[31:0];
  end else begin : g_dw32
    assign inst_word = rsp_data[31:0];
  end

endmodule

// File: rtl/lemon_ifu.sv
// rtl/lemon_ifu.sv - multi-cycle instruction fetch unit
//
// Purpose: owns the architectural PC, issues one fetch at a time over a
// valid/ready request channel and hands 32-bit instructions with their PC to
// decode. Redirects are accepted in any state.
// Optional feature: IFU_MISALIGN_CHK_EN adds misaligned-redirect detection,
// the FAULT state and the fault port; without it redirect_pc[1:0] is cleared.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_req_valid/ready/addr          fetch request channel (addr == pc)
//   mem_rsp_valid/data                fetch response, no back-pressure
//   inst_valid/ready, inst, inst_pc   instruction channel to decode
//   fault                             misaligned redirect (optional)
//   redirect_valid, redirect_pc       branch/jump redirect pulse

module lemon_ifu
  import lemon_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              MEM_DW    = 64,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [MEM_DW-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ILEN-1:0]   inst,
  output logic [XLEN-1:0]   inst_pc,
`ifdef IFU_MISALIGN_CHK_EN
  output logic              fault,
`endif
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic            kill_q, kill_d;
  logic [ILEN-1:0] rsp_word;
  logic [XLEN-1:0] redirect_tgt;

`ifdef IFU_MISALIGN_CHK_EN
  logic fault_q, fault_d;
  logic redirect_bad;
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
`endif

  ifu_word_sel #(.MEM_DW(MEM_DW)) u_word_sel (
    .rsp_data  (mem_rsp_data),
    .pc_bit2   (pc_q[2]),
    .inst_word (rsp_word)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      IFU_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // The old request still goes out; its response must be discarded.
          if (mem_req_ready) begin
            kill_d  = 1'b1;
            state_d = IFU_WAIT;
          end
        end else if (mem_req_ready) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (mem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            inst_d    = rsp_word;
            inst_pc_d = pc_q;
            state_d   = IFU_OUT;
          end
        end
      end
      IFU_OUT: begin
        // A redirect wins over pc+4 even if decode takes the instruction.
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = IFU_REQ;
        end
      end
      default: begin
        // FAULT: held until reset.
      end
    endcase
`ifdef IFU_MISALIGN_CHK_EN
    if (redirect_bad && (state_q != IFU_FAULT)) begin
      state_d = IFU_FAULT;
      pc_d    = pc_q;
      kill_d  = 1'b0;
      fault_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IFU_REQ;
      pc_q      <= RESET_VEC;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
`ifdef IFU_MISALIGN_CHK_EN
      fault_q   <= fault_d;
`endif
    end
  end

  // Gated by rst so no request is offered during the reset cycle.
  assign mem_req_valid = (state_q == IFU_REQ) && !rst;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (state_q == IFU_OUT);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
  assign fault         = fault_q;
`endif

endmodule

// File: tb/tb_lemon_ifu.sv
// tb/tb_lemon_ifu.sv - self-checking bench for lemon_ifu

module tb_lemon_ifu;

  localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic        fault;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lemon_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef IFU_MISALIGN_CHK_EN
    .fault          (fault),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: each aligned word holds a value unique to its address.
  function automatic logic [31:0] whash(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5BD1_E995 ^ a[63:32];
  endfunction

  function automatic logic [63:0] mdata(input logic [63:0] a);
    return {whash({a[63:3], 3'b100}), whash({a[63:3], 3'b000})};
  endfunction

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete fetch starting in REQ at address a, decode stalled for
  // 'stall' cycles once the instruction is presented.
  task automatic fetch_one(input logic [63:0] a, input int stall);
    chk("f_req_valid", mem_req_valid, 1'b1);
    chk("f_req_addr", mem_req_addr, a);
    chk("f_req_inst_valid", inst_valid, 1'b0);
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    chk("f_wait_req_valid", mem_req_valid, 1'b0);
    chk("f_wait_inst_valid", inst_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = mdata(a);
    adv();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = {$urandom, $urandom};
    for (int i = 0; i < stall; i++) begin
      chk("f_stall_inst", inst, whash(a));
      chk("f_stall_pc", inst_pc, a);
      chk("f_stall_req_valid", mem_req_valid, 1'b0);
      adv();
    end
    chk("f_inst_valid", inst_valid, 1'b1);
    chk("f_inst", inst, whash(a));
    chk("f_inst_pc", inst_pc, a);
    chk("f_out_req_valid", mem_req_valid, 1'b0);
    inst_ready = 1'b1;
    adv();
    inst_ready = 1'b0;
  endtask

  logic [63:0] exp_pc;
  logic [63:0] p_addr;
  logic [63:0] tgt;
  logic        pending;
  logic        hs;
  int          dly;
  int          n_deliv;

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    adv();
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    rst = 1'b0;
    #1;
    chk("rel_req_valid", mem_req_valid, 1'b1);
    chk("rel_req_addr", mem_req_addr, RV);

    // Free-running fetch, low/high/low word selection, then a decode stall.
    fetch_one(RV, 0);
    fetch_one(RV + 64'd4, 0);
    fetch_one(RV + 64'd8, 0);
    fetch_one(RV + 64'd12, 5);

    // Redirect in WAIT; late response must be dropped.
    chk("rw_addr", mem_req_addr, RV + 64'd16);
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1000;
    adv();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rw_hold_inst_valid", inst_valid, 1'b0);
      chk("rw_hold_req_valid", mem_req_valid, 1'b0);
      adv();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    adv();
    mem_rsp_valid = 1'b0;
    chk("rw_drop_inst_valid", inst_valid, 1'b0);
    chk("rw_req_valid", mem_req_valid, 1'b1);
    chk("rw_req_addr", mem_req_addr, 64'h8000_1000);

    // Redirect together with the response.
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = mdata(64'h8000_1000);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    adv();
    mem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("rr_inst_valid", inst_valid, 1'b0);
    chk("rr_req_valid", mem_req_valid, 1'b1);
    chk("rr_req_addr", mem_req_addr, 64'h8000_2000);

    // Redirect together with inst_ready.
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = mdata(64'h8000_2000);
    adv();
    mem_rsp_valid = 1'b0;
    chk("ri_inst_valid", inst_valid, 1'b1);
    chk("ri_inst", inst, whash(64'h8000_2000));
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_3000;
    adv();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("ri_after_inst_valid", inst_valid, 1'b0);
    fetch_one(64'h8000_3000, 0);

    // Reset while waiting for a response; the late response is ignored.
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    adv();
    rst = 1'b0;
    #1;
    chk("rm_req_valid", mem_req_valid, 1'b1);
    chk("rm_req_addr", mem_req_addr, RV);
    chk("rm_inst_valid", inst_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = mdata(64'h8000_3004);
    adv();
    mem_rsp_valid = 1'b0;
    chk("rm_late_inst_valid", inst_valid, 1'b0);
    chk("rm_late_req_addr", mem_req_addr, RV);
    fetch_one(RV, 0);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0002;
    adv();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      chk("ma_fault", fault, 1'b1);
      chk("ma_req_valid", mem_req_valid, 1'b0);
      chk("ma_inst_valid", inst_valid, 1'b0);
      mem_req_ready = 1'b1;
      inst_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = mdata(RV);
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_4000;
      adv();
    end
    mem_req_ready = 1'b0;
    inst_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("ma_fault_sticky", fault, 1'b1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    #1;
    chk("ma_fault_cleared", fault, 1'b0);
    fetch_one(RV, 0);
`else
    chk("ma_req_valid", mem_req_valid, 1'b1);
    chk("ma_req_addr", mem_req_addr, 64'h8000_0000);
    fetch_one(RV, 0);
`endif

    // Randomised traffic against an address-level reference model.
    exp_pc = RV + 64'd4;
    pending = 1'b0;
    p_addr = '0;
    dly = 0;
    n_deliv = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      tgt = RV + 64'($urandom_range(0, 1023)) * 64'd4;
`ifndef IFU_MISALIGN_CHK_EN
      tgt[1:0] = 2'($urandom_range(0, 3));
`endif
      redirect_pc = tgt;
      mem_rsp_valid = pending && (dly == 0);
      mem_rsp_data = mem_rsp_valid ? mdata(p_addr) : {$urandom, $urandom};
      #1;
      chk("rnd_excl", mem_req_valid && inst_valid, 1'b0);
      if (rst) chk("rnd_rst_req_valid", mem_req_valid, 1'b0);
      if (mem_req_valid) chk("rnd_req_addr", mem_req_addr, exp_pc);
      if (inst_valid) begin
        chk("rnd_inst_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, whash(inst_pc));
      end
      if (rst) begin
        exp_pc = RV;
        pending = 1'b0;
      end else begin
        hs = mem_req_valid && mem_req_ready;
        if (hs) chk("rnd_one_outstanding", pending, 1'b0);
        if (mem_rsp_valid) pending = 1'b0;
        else if (pending) dly--;
        if (hs) begin
          pending = 1'b1;
          p_addr = mem_req_addr;
          dly = $urandom_range(0, 3);
        end
        if (inst_valid && inst_ready) n_deliv++;
        if (redirect_valid) exp_pc = redirect_pc & ~64'd3;
        else if (inst_valid && inst_ready) exp_pc = exp_pc + 64'd4;
      end
      adv();
    end
    rst = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_progress", n_deliv > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
